// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the write-back port arbiter.
// Used by wb_skid_fifo and wb_port_arbiter.
package wb_arb_pkg;

   localparam int WB_DATA_W     = 32;
   localparam int WB_TAG_W      = 6;
   localparam int WB_FIFO_DEPTH = 2;

   typedef enum logic {
      WB_SRC_ALU  = 1'b0,
      WB_SRC_LOAD = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [WB_TAG_W-1:0]  tag;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   function automatic wb_src_e other_src(input wb_src_e s);
      return (s == WB_SRC_ALU) ? WB_SRC_LOAD : WB_SRC_ALU;
   endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small per-requester FIFO feeding the write-back arbiter.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_skid_fifo
   import wb_arb_pkg::*;
#(
   parameter int  DEPTH = WB_FIFO_DEPTH,
   parameter type T     = wb_entry_t,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic          i_pop,
   input  T              i_din,
   output T              o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;
   logic          w_clear;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_clear = rst | i_flush;
   // A full FIFO refuses a push even in a cycle it pops.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !w_clear) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU and load.
// Define WB_ARB_BYPASS_EN to let a request skip an empty FIFO when granted.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int  DATA_WIDTH = WB_DATA_W,
   parameter int  TAG_WIDTH  = WB_TAG_W,
   parameter int  FIFO_DEPTH = WB_FIFO_DEPTH,
   localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [TAG_WIDTH-1:0]  alu_tag,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [TAG_WIDTH-1:0]  ld_tag,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  wb_valid,
   output logic [TAG_WIDTH-1:0]  wb_tag,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_src,
   output logic [CW-1:0]         alu_count,
   output logic [CW-1:0]         ld_count
);

   typedef struct packed {
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t  w_alu_in;
   entry_t  w_ld_in;
   entry_t  w_alu_head;
   entry_t  w_ld_head;
   entry_t  w_grant_entry;
   logic    w_alu_full;
   logic    w_alu_empty;
   logic    w_ld_full;
   logic    w_ld_empty;
   logic    w_alu_req;
   logic    w_ld_req;
   logic    w_alu_byp;
   logic    w_ld_byp;
   logic    w_alu_cand;
   logic    w_ld_cand;
   logic    w_grant_valid;
   wb_src_e w_grant_src;
   wb_src_e w_rr_nxt;
   logic    w_alu_gnt;
   logic    w_ld_gnt;
   logic    w_alu_push;
   logic    w_ld_push;
   logic    w_alu_pop;
   logic    w_ld_pop;

   wb_src_e                 r_rr;
   logic                    r_wb_valid;
   logic [TAG_WIDTH-1:0]    r_wb_tag;
   logic [DATA_WIDTH-1:0]   r_wb_data;
   wb_src_e                 r_wb_src;

   assign w_alu_in.tag  = alu_tag;
   assign w_alu_in.data = alu_data;
   assign w_ld_in.tag   = ld_tag;
   assign w_ld_in.data  = ld_data;

   // Ready is held low through reset and otherwise tracks occupancy only.
   assign alu_ready = ~rst & ~w_alu_full;
   assign ld_ready  = ~rst & ~w_ld_full;
   assign w_alu_req = alu_valid & alu_ready;
   assign w_ld_req  = ld_valid & ld_ready;

`ifdef WB_ARB_BYPASS_EN
   assign w_alu_byp = w_alu_empty & w_alu_req;
   assign w_ld_byp  = w_ld_empty & w_ld_req;
`else
   assign w_alu_byp = 1'b0;
   assign w_ld_byp  = 1'b0;
`endif

   assign w_alu_cand = ~w_alu_empty | w_alu_byp;
   assign w_ld_cand  = ~w_ld_empty | w_ld_byp;

   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_src   = r_rr;
      w_rr_nxt      = r_rr;
      if (!flush) begin
         case ({w_alu_cand, w_ld_cand})
            2'b11: begin
               w_grant_valid = 1'b1;
               w_grant_src   = r_rr;
               w_rr_nxt      = other_src(r_rr);
            end
            2'b10: begin
               w_grant_valid = 1'b1;
               w_grant_src   = WB_SRC_ALU;
            end
            2'b01: begin
               w_grant_valid = 1'b1;
               w_grant_src   = WB_SRC_LOAD;
            end
            default: begin
               w_grant_valid = 1'b0;
            end
         endcase
      end
   end

   assign w_alu_gnt = w_grant_valid & (w_grant_src == WB_SRC_ALU);
   assign w_ld_gnt  = w_grant_valid & (w_grant_src == WB_SRC_LOAD);

   // A granted bypass request never lands in its FIFO.
   assign w_alu_pop  = w_alu_gnt & ~w_alu_byp;
   assign w_ld_pop   = w_ld_gnt & ~w_ld_byp;
   assign w_alu_push = w_alu_req & ~(w_alu_gnt & w_alu_byp);
   assign w_ld_push  = w_ld_req & ~(w_ld_gnt & w_ld_byp);

   always_comb begin
      w_grant_entry = w_alu_head;
      if (w_grant_src == WB_SRC_ALU) begin
         w_grant_entry = w_alu_byp ? w_alu_in : w_alu_head;
      end else begin
         w_grant_entry = w_ld_byp ? w_ld_in : w_ld_head;
      end
   end

   wb_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t)
   ) u_alu_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_alu_push),
      .i_pop   (w_alu_pop),
      .i_din   (w_alu_in),
      .o_head  (w_alu_head),
      .o_count (alu_count),
      .o_full  (w_alu_full),
      .o_empty (w_alu_empty)
   );

   wb_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t)
   ) u_ld_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_ld_push),
      .i_pop   (w_ld_pop),
      .i_din   (w_ld_in),
      .o_head  (w_ld_head),
      .o_count (ld_count),
      .o_full  (w_ld_full),
      .o_empty (w_ld_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr       <= WB_SRC_LOAD;
         r_wb_valid <= 1'b0;
         r_wb_tag   <= '0;
         r_wb_data  <= '0;
         r_wb_src   <= WB_SRC_ALU;
      end else begin
         r_rr       <= w_rr_nxt;
         r_wb_valid <= w_grant_valid;
         if (w_grant_valid) begin
            r_wb_tag  <= w_grant_entry.tag;
            r_wb_data <= w_grant_entry.data;
            r_wb_src  <= w_grant_src;
         end
      end
   end

   assign wb_valid = r_wb_valid;
   assign wb_tag   = r_wb_tag;
   assign wb_data  = r_wb_data;
   assign wb_src   = r_wb_src;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-level reference model,
// random and directed traffic, monitor checks every write-back.
module tb_wb_port_arbiter;

   localparam int DW = 32;
   localparam int TW = 6;
   localparam int D  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          alu_valid;
   logic          alu_ready;
   logic [TW-1:0] alu_tag;
   logic [DW-1:0] alu_data;
   logic          ld_valid;
   logic          ld_ready;
   logic [TW-1:0] ld_tag;
   logic [DW-1:0] ld_data;
   logic          wb_valid;
   logic [TW-1:0] wb_tag;
   logic [DW-1:0] wb_data;
   logic          wb_src;
   logic [1:0]    alu_count;
   logic [1:0]    ld_count;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .FIFO_DEPTH (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_tag   (alu_tag),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_tag    (ld_tag),
      .ld_data   (ld_data),
      .wb_valid  (wb_valid),
      .wb_tag    (wb_tag),
      .wb_data   (wb_data),
      .wb_src    (wb_src),
      .alu_count (alu_count),
      .ld_count  (ld_count)
   );

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } req_t;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic          src;
      int            cyc;
   } exp_t;

   req_t pend0[$];
   req_t pend1[$];
   req_t mq0[$];
   req_t mq1[$];
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit rr = 1'b1;
   int ntag = 1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic add(input bit s, input logic [TW-1:0] t,
                      input logic [DW-1:0] d);
      req_t q;
      q.tag  = t;
      q.data = d;
      if (s) pend1.push_back(q);
      else pend0.push_back(q);
   endtask

   task automatic add_auto(input bit s);
      add(s, TW'(ntag), $urandom);
      ntag = (ntag + 1) % 64;
   endtask

   // One clock: drive inputs, check readys/counts, advance the model.
   task automatic step(input bit r, input bit f, input bit en0, input bit en1);
      bit   v0, v1, a0, a1, c0, c1, byp0, byp1, g, gs;
      req_t in0, in1, e;
      exp_t x;
      @(posedge clk);
      #1;
      rst   = r;
      flush = f;
      v0 = en0 && (pend0.size() > 0);
      v1 = en1 && (pend1.size() > 0);
      if (v0) in0 = pend0[0];
      else begin in0.tag = TW'($urandom); in0.data = $urandom; end
      if (v1) in1 = pend1[0];
      else begin in1.tag = TW'($urandom); in1.data = $urandom; end
      alu_valid = v0;
      alu_tag   = in0.tag;
      alu_data  = in0.data;
      ld_valid  = v1;
      ld_tag    = in1.tag;
      ld_data   = in1.data;
      #1;
      a0 = !r && (mq0.size() < D);
      a1 = !r && (mq1.size() < D);
      chk("alu_ready", alu_ready, a0);
      chk("ld_ready", ld_ready, a1);
      chk("alu_count", alu_count, mq0.size());
      chk("ld_count", ld_count, mq1.size());
      if (v0 && a0) void'(pend0.pop_front());
      if (v1 && a1) void'(pend1.pop_front());
      if (r) begin
         mq0.delete();
         mq1.delete();
         rr = 1'b1;
      end else if (f) begin
         mq0.delete();
         mq1.delete();
      end else begin
         byp0 = 1'b0;
         byp1 = 1'b0;
`ifdef WB_ARB_BYPASS_EN
         byp0 = v0 && a0 && (mq0.size() == 0);
         byp1 = v1 && a1 && (mq1.size() == 0);
`endif
         c0 = (mq0.size() > 0) || byp0;
         c1 = (mq1.size() > 0) || byp1;
         g  = c0 || c1;
         if (c0 && c1) begin
            gs = rr;
            rr = !rr;
         end else begin
            gs = c1;
         end
         if (g) begin
            if (!gs) e = byp0 ? in0 : mq0.pop_front();
            else e = byp1 ? in1 : mq1.pop_front();
            x.tag  = e.tag;
            x.data = e.data;
            x.src  = gs;
            x.cyc  = cyc + 1;
            sb.push_back(x);
         end
         if (v0 && a0 && !(g && !gs && byp0)) mq0.push_back(in0);
         if (v1 && a1 && !(g && gs && byp1)) mq1.push_back(in1);
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (pend0.size() > 0 || pend1.size() > 0); i++)
         step(0, 0, 1, 1);
      chk("drain_budget", pend0.size() + pend1.size(), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic chk_outputs_zero(input string nm);
      @(negedge clk);
      chk({nm, "_wb_valid"}, wb_valid, 0);
      chk({nm, "_wb_tag"}, wb_tag, 0);
      chk({nm, "_wb_data"}, wb_data, 0);
      chk({nm, "_wb_src"}, wb_src, 0);
   endtask

   always @(negedge clk) begin
      exp_t m;
      if (mon_en) begin
         if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wb: got tag %0h data %0h src %0d, expected none",
                        wb_tag, wb_data, wb_src);
            end else begin
               m = sb.pop_front();
               chk("wb_tag", wb_tag, m.tag);
               chk("wb_data", wb_data, m.data);
               chk("wb_src", wb_src, m.src);
               chk("wb_cycle", cyc, m.cyc);
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_wb: got wb_valid %0b expected tag %0h at cycle %0d",
                     wb_valid, sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      alu_tag   = '0;
      alu_data  = '0;
      ld_tag    = '0;
      ld_data   = '0;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk_outputs_zero("reset");
      mon_en = 1'b1;
      idle(2);

      add(0, 6'd5, 32'hDEADBEEF);
      step(0, 0, 1, 0);
      idle(4);

      for (int i = 0; i < 4; i++) begin
         add_auto(0);
         add_auto(1);
      end
      drain(20);
      idle(4);

      for (int i = 0; i < 6; i++) add_auto(0);
      drain(30);
      idle(4);

      for (int i = 0; i < 3; i++) begin
         add_auto(0);
         add_auto(1);
      end
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      add_auto(0);
      add_auto(1);
      step(0, 1, 1, 1);
      pend0.delete();
      pend1.delete();
      idle(3);
      add(0, 6'd0, 32'h0000_1111);
      add(1, 6'd0, 32'h0000_2222);
      step(0, 0, 1, 1);
      idle(4);

      for (int i = 0; i < 4; i++) begin
         add_auto(0);
         add_auto(1);
      end
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(1, 1, 1, 1);
      pend0.delete();
      pend1.delete();
      step(0, 0, 0, 0);
      chk_outputs_zero("mid_reset");
      add_auto(0);
      add_auto(1);
      step(0, 0, 1, 1);
      idle(4);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) == 0 && pend0.size() < 4) add_auto(0);
         if ($urandom_range(0, 2) == 0 && pend1.size() < 4) add_auto(1);
         step($urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
      drain(40);
      idle(6);
      chk("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
